ifu_fetch_ctrl: RTL and testbench

//   Parametrised instruction-fetch unit: owns the PC and fetches from an instruction memory over a req/gnt/rvalid handshake.

---
 rtl/ifu_fetch_ctrl.sv | 125 ++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - instruction-fetch controller: PC ownership, prioritised redirects,
// AdEL check and a single-outstanding req/gnt/rvalid instruction-memory handshake.
module ifu_fetch_ctrl #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [XLEN-1:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [XLEN-1:0] IM_BASE    = 32'h0000_3000,
  parameter logic [XLEN-1:0] IM_LIMIT   = 32'h0000_6FFF,
  parameter int              PC_STEP    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            exc_enter,
  input  logic            eret,
  input  logic [XLEN-1:0] epc,
  output logic            im_req,
  output logic [XLEN-1:0] im_addr,
  input  logic            im_gnt,
  input  logic            im_rvalid,
  input  logic [31:0]     im_rdata,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc8,
  output logic            if_exc,
  output logic [4:0]      if_exc_code
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_KILL, S_HOLD} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n, target;
  logic            redirect, bad, gnt_acc;
  logic            load_fetch, load_exc, clr_valid;

  always_comb begin
    target = redirect_pc;
    if (exc_enter)  target = EXC_VECTOR;
    else if (eret)  target = epc;
  end

  assign redirect = exc_enter | eret | redirect_valid;
  assign bad      = (pc[1:0] != 2'b00) | (pc < IM_BASE) | (pc > IM_LIMIT);
  assign im_req   = (state == S_REQ) & ~bad;
  assign im_addr  = pc;
  // A grant only counts while a request is actually being driven.
  assign gnt_acc  = im_req & im_gnt;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    load_fetch = 1'b0;
    load_exc   = 1'b0;
    clr_valid  = 1'b0;
    case (state)
      S_REQ: begin
        if (redirect) begin
          pc_n      = target;
          clr_valid = 1'b1;
          state_n   = gnt_acc ? S_KILL : S_REQ;
        end else if (bad) begin
          load_exc = 1'b1;
          state_n  = S_HOLD;
        end else if (gnt_acc) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_n      = target;
          clr_valid = 1'b1;
          state_n   = im_rvalid ? S_REQ : S_KILL;
        end else if (im_rvalid) begin
          load_fetch = 1'b1;
          state_n    = S_HOLD;
        end
      end
      S_KILL: begin
        if (redirect) pc_n = target;
        if (im_rvalid) state_n = S_REQ;
      end
      S_HOLD: begin
        if (redirect) begin
          pc_n      = target;
          clr_valid = 1'b1;
          state_n   = S_REQ;
        end else if (!stall) begin
          pc_n      = pc + XLEN'(PC_STEP);
          clr_valid = 1'b1;
          state_n   = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= 32'd0;
      if_pc       <= RESET_PC;
      if_pc8      <= RESET_PC + XLEN'(8);
      if_exc      <= 1'b0;
      if_exc_code <= 5'd0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (clr_valid) if_valid <= 1'b0;
      if (load_fetch || load_exc) begin
        if_valid    <= 1'b1;
        if_instr    <= load_fetch ? im_rdata : 32'd0;
        if_pc       <= pc;
        if_pc8      <= pc + XLEN'(8);
        if_exc      <= load_exc;
        if_exc_code <= load_exc ? 5'd4 : 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb/tb_ifu_fetch_ctrl.sv - scoreboard bench for ifu_fetch_ctrl.
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, exc_enter, eret;
  logic [31:0] redirect_pc, epc;
  logic        im_req, im_gnt, im_rvalid;
  logic [31:0] im_addr, im_rdata;
  logic        if_valid, if_exc;
  logic [31:0] if_instr, if_pc, if_pc8;
  logic [4:0]  if_exc_code;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic last_valid = 1'b0;

  ifu_fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_enter(exc_enter), .eret(eret), .epc(epc),
    .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc8(if_pc8),
    .if_exc(if_exc), .if_exc_code(if_exc_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h3000) ? 32'h3C01_0001 : (a ^ 32'hA5A5_0000);
  endfunction

  // New presentation = rising if_valid (consumption always leaves a gap cycle).
  always @(negedge clk) begin
    if (!reset && if_valid && !last_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("if_pc", if_pc, e.pc);
        check("if_pc8", if_pc8, e.pc + 32'd8);
        check("if_instr", if_instr, e.instr);
        check("if_exc", {31'd0, if_exc}, {31'd0, e.exc});
        check("if_exc_code", {27'd0, if_exc_code}, e.exc ? 32'd4 : 32'd0);
      end
    end
    last_valid = if_valid;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1; redirect_pc = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  // Full fetch from REQ: grant now, response after 'gap' idle cycles, then consume.
  task automatic fetch(input logic [31:0] a, input int gap);
    check("req", {31'd0, im_req}, 32'd1);
    check("addr", im_addr, a);
    exp_q.push_back('{pc: a, instr: mem_word(a), exc: 1'b0});
    im_gnt = 1'b1;
    tick();
    im_gnt = 1'b0;
    for (int i = 0; i < gap; i++) tick();
    im_rvalid = 1'b1; im_rdata = mem_word(a);
    tick();
    im_rvalid = 1'b0; im_rdata = 32'hDEAD_BEEF;
    check("valid_after_rvalid", {31'd0, if_valid}, 32'd1);
    tick();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; exc_enter = 1'b0; eret = 1'b0;
    redirect_pc = 32'd0; epc = 32'd0; im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = 32'd0;
    @(negedge clk);
    tick();
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'h3000);
    check("rst_if_pc8", if_pc8, 32'h3008);
    check("rst_instr", if_instr, 32'd0);
    check("rst_exc", {27'd0, if_exc_code, if_exc}, 32'd0);
    reset = 1'b0;

    // Basic fetch with latency check, then stall hold in HOLD.
    check("req0", {31'd0, im_req}, 32'd1);
    check("addr0", im_addr, 32'h3000);
    exp_q.push_back('{pc: 32'h3000, instr: 32'h3C01_0001, exc: 1'b0});
    im_gnt = 1'b1;
    tick();
    im_gnt = 1'b0; im_rvalid = 1'b1; im_rdata = 32'h3C01_0001;
    check("c1_not_valid", {31'd0, if_valid}, 32'd0);
    tick();
    im_rvalid = 1'b0;
    check("c2_valid", {31'd0, if_valid}, 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", {31'd0, if_valid}, 32'd1);
      check("stall_noreq", {31'd0, im_req}, 32'd0);
      check("stall_pc", if_pc, 32'h3000);
      check("stall_instr", if_instr, 32'h3C01_0001);
    end
    stall = 1'b0;
    tick();
    check("consumed", {31'd0, if_valid}, 32'd0);
    fetch(32'h3004, 0);

    // Redirect while waiting: killed response discarded, refetch target.
    im_gnt = 1'b1;
    check("addr_kill", im_addr, 32'h3008);
    tick();
    im_gnt = 1'b0;
    redirect_to(32'h3100);
    check("kill_noreq", {31'd0, im_req}, 32'd0);
    tick();
    im_rvalid = 1'b1; im_rdata = 32'h1111_2222;
    tick();
    im_rvalid = 1'b0;
    check("kill_no_valid", {31'd0, if_valid}, 32'd0);
    fetch(32'h3100, 0);

    // Simultaneous redirects: exception wins; then ERET.
    exc_enter = 1'b1; eret = 1'b1; epc = 32'h3500;
    redirect_to(32'h3200);
    exc_enter = 1'b0; eret = 1'b0;
    check("exc_vec", im_addr, 32'h4180);
    eret = 1'b1; epc = 32'h3008;
    tick();
    eret = 1'b0;
    fetch(32'h3008, 1);

    // AdEL: misaligned, above limit, below base; top legal word accepted.
    redirect_to(32'h3002);
    check("mis_noreq", {31'd0, im_req}, 32'd0);
    exp_q.push_back('{pc: 32'h3002, instr: 32'd0, exc: 1'b1});
    tick();
    redirect_to(32'h7000);
    check("hi_noreq", {31'd0, im_req}, 32'd0);
    exp_q.push_back('{pc: 32'h7000, instr: 32'd0, exc: 1'b1});
    tick();
    redirect_to(32'h2FFC);
    check("lo_noreq", {31'd0, im_req}, 32'd0);
    exp_q.push_back('{pc: 32'h2FFC, instr: 32'd0, exc: 1'b1});
    tick();
    redirect_to(32'h6FFC);
    fetch(32'h6FFC, 0);

    // Grant withheld: request stable, redirect mid-way moves the address.
    redirect_to(32'h3000);
    check("nogrant_addr0", im_addr, 32'h3000);
    tick();
    check("nogrant_addr1", im_addr, 32'h3000);
    redirect_to(32'h3010);
    for (int i = 0; i < 2; i++) begin
      check("nogrant_req", {31'd0, im_req}, 32'd1);
      check("nogrant_addr2", im_addr, 32'h3010);
      tick();
    end
    fetch(32'h3010, 2);

    // Stray rvalid outside WAIT/KILL must be ignored.
    im_rvalid = 1'b1;
    tick();
    im_rvalid = 1'b0;
    check("stray_rvalid", {31'd0, if_valid}, 32'd0);

    tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
